// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/LSU memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_IF,
    SERVE_LSU
  } arb_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;
  localparam logic [3:0]  FULL_MASK              = 4'hF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Counts cycles spent serving a transaction; flags the cycle in which the
// limit is reached. Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      count <= '0;
    end else if (active && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  // count holds (serve cycle - 1), so the limit is hit in serve cycle TimeoutCycles
  assign expired = active && (count == 8'(TimeoutCycles - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch / LSU) arbiter onto a single memory port, LSU priority.
// Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_request,
  input  logic [DataWidth-1:0] if_addr,
  output logic                 if_data_valid,
  output logic [DataWidth-1:0] if_rdata,
  input  logic                 lsu_request,
  input  logic                 lsu_we_re,
  input  logic [3:0]           lsu_mask,
  input  logic [DataWidth-1:0] lsu_addr,
  input  logic [DataWidth-1:0] lsu_wdata,
  output logic                 lsu_data_valid,
  output logic [DataWidth-1:0] lsu_rdata,
  output logic                 mem_request,
  output logic                 mem_we_re,
  output logic [3:0]           mem_mask,
  output logic [DataWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic                 mem_data_valid,
  input  logic [DataWidth-1:0] mem_rdata,
  output logic                 timeout_err
);

  arb_state_e state;
  logic       expired;
  logic       done;

  if (TimeoutCycles < 2 || TimeoutCycles > 255) begin : g_bad_timeout
    $error("mem_arbiter: TimeoutCycles must be in 2..255");
  end

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TimeoutCycles(TimeoutCycles)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .start  ((state == IDLE) && (lsu_request || if_request)),
    .active (state != IDLE),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif

  assign done = mem_data_valid || expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_request <= 1'b0;
      mem_we_re   <= 1'b0;
      mem_mask    <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_request) begin
            state       <= SERVE_LSU;
            mem_request <= 1'b1;
            mem_we_re   <= lsu_we_re;
            mem_mask    <= lsu_mask;
            mem_addr    <= lsu_addr;
            mem_wdata   <= lsu_we_re ? lsu_wdata : '0;
          end else if (if_request) begin
            state       <= SERVE_IF;
            mem_request <= 1'b1;
            mem_we_re   <= 1'b0;
            mem_mask    <= FULL_MASK;
            mem_addr    <= if_addr;
            mem_wdata   <= '0;
          end
        end
        SERVE_IF, SERVE_LSU: begin
          if (done) begin
            state       <= IDLE;
            mem_request <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          mem_request <= 1'b0;
        end
      endcase
    end
  end

  // Completion is combinational in the serving cycle; reset suppresses it so
  // an aborted transaction never reports completion.
  always_comb begin
    if_data_valid  = 1'b0;
    lsu_data_valid = 1'b0;
    if_rdata       = '0;
    lsu_rdata      = '0;
    timeout_err    = 1'b0;
    if (!rst && done) begin
      if (state == SERVE_IF) begin
        if_data_valid = 1'b1;
        if_rdata      = mem_data_valid ? mem_rdata : '0;
      end else if (state == SERVE_LSU) begin
        lsu_data_valid = 1'b1;
        lsu_rdata      = mem_data_valid ? mem_rdata : '0;
      end
      timeout_err = (state != IDLE) && !mem_data_valid;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: driver pushes expected completions into a
// scoreboard queue, an independent negedge monitor pops and compares them.
module tb_mem_arbiter;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_request;
  logic [DW-1:0] if_addr;
  logic          if_data_valid;
  logic [DW-1:0] if_rdata;
  logic          lsu_request;
  logic          lsu_we_re;
  logic [3:0]    lsu_mask;
  logic [DW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic          lsu_data_valid;
  logic [DW-1:0] lsu_rdata;
  logic          mem_request;
  logic          mem_we_re;
  logic [3:0]    mem_mask;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_data_valid;
  logic [DW-1:0] mem_rdata;
  logic          timeout_err;

  mem_arbiter #(
    .DataWidth    (DW),
    .TimeoutCycles(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_request    (if_request),
    .if_addr       (if_addr),
    .if_data_valid (if_data_valid),
    .if_rdata      (if_rdata),
    .lsu_request   (lsu_request),
    .lsu_we_re     (lsu_we_re),
    .lsu_mask      (lsu_mask),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_data_valid(lsu_data_valid),
    .lsu_rdata     (lsu_rdata),
    .mem_request   (mem_request),
    .mem_we_re     (mem_we_re),
    .mem_mask      (mem_mask),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_data_valid(mem_data_valid),
    .mem_rdata     (mem_rdata),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_lsu;
    logic [DW-1:0] rdata;
    logic          to;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_lsu, input logic [DW-1:0] rdata, input logic to);
    exp_t e;
    e.is_lsu = is_lsu;
    e.rdata  = rdata;
    e.to     = to;
    sb.push_back(e);
  endtask

  task automatic check_port(input string tag, input logic req, input logic we,
                            input logic [3:0] mask, input logic [DW-1:0] addr,
                            input logic [DW-1:0] wdata);
    check({tag, "_mem_request"}, DW'(mem_request), DW'(req));
    check({tag, "_mem_we_re"},   DW'(mem_we_re),   DW'(we));
    check({tag, "_mem_mask"},    DW'(mem_mask),    DW'(mask));
    check({tag, "_mem_addr"},    mem_addr,         addr);
    check({tag, "_mem_wdata"},   mem_wdata,        wdata);
  endtask

  // Monitor: every completion must match the head of the scoreboard.
  exp_t m;
  always @(negedge clk) begin
    if (!rst) begin
      if (if_data_valid || lsu_data_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got if=%0b lsu=%0b expected none", if_data_valid, lsu_data_valid);
        end else begin
          m = sb.pop_front();
          check("if_data_valid",  DW'(if_data_valid),  DW'(!m.is_lsu));
          check("lsu_data_valid", DW'(lsu_data_valid), DW'(m.is_lsu));
          check("owner_rdata", m.is_lsu ? lsu_rdata : if_rdata, m.rdata);
          check("other_rdata", m.is_lsu ? if_rdata : lsu_rdata, '0);
          check("timeout_err", DW'(timeout_err), DW'(m.to));
        end
      end else begin
        check("idle_rdata", if_rdata | lsu_rdata, '0);
        check("idle_timeout_err", DW'(timeout_err), '0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    if_request = 1'b0; if_addr = '0;
    lsu_request = 1'b0; lsu_we_re = 1'b0; lsu_mask = '0; lsu_addr = '0; lsu_wdata = '0;
    mem_data_valid = 1'b0; mem_rdata = '0;
    tick();
    tick();
    check_port("reset", 1'b0, 1'b0, 4'h0, '0, '0);
    check("reset_if_valid",  DW'(if_data_valid),  '0);
    check("reset_lsu_valid", DW'(lsu_data_valid), '0);
    rst = 1'b0;
    tick();

    // Both request together: LSU store wins, IF follows after an IDLE cycle.
    lsu_request = 1'b1; lsu_we_re = 1'b1; lsu_mask = 4'b0011;
    lsu_addr = 32'h100; lsu_wdata = 32'hCAFEF00D;
    if_request = 1'b1; if_addr = 32'h40;
    tick();
    check_port("prio_lsu", 1'b1, 1'b1, 4'b0011, 32'h100, 32'hCAFEF00D);
    push(1'b1, 32'h11112222, 1'b0);
    mem_rdata = 32'h11112222; mem_data_valid = 1'b1;
    tick();
    mem_data_valid = 1'b0; lsu_request = 1'b0;
    check("prio_idle_gap_mem_request", DW'(mem_request), '0);
    tick();
    check_port("prio_if", 1'b1, 1'b0, 4'hF, 32'h40, '0);
    push(1'b0, 32'hDEADBEEF, 1'b0);
    mem_rdata = 32'hDEADBEEF; mem_data_valid = 1'b1;
    tick();
    mem_data_valid = 1'b0; if_request = 1'b0;
    tick();

    // IF-only read, memory answers in the third serve cycle.
    if_request = 1'b1; if_addr = 32'h40;
    tick();
    check_port("if_read", 1'b1, 1'b0, 4'hF, 32'h40, '0);
    tick();
    check("if_read_held_mem_request", DW'(mem_request), 32'h1);
    tick();
    push(1'b0, 32'hDEADBEEF, 1'b0);
    mem_rdata = 32'hDEADBEEF; mem_data_valid = 1'b1;
    tick();
    mem_data_valid = 1'b0; if_request = 1'b0;
    tick();

    // Memory valid while IDLE must be ignored.
    mem_rdata = 32'hA5A5A5A5; mem_data_valid = 1'b1;
    check("idle_mdv_if_valid",  DW'(if_data_valid),  '0);
    check("idle_mdv_lsu_valid", DW'(lsu_data_valid), '0);
    tick();
    tick();
    mem_data_valid = 1'b0;
    tick();

    // Reset during SERVE_LSU aborts without completion.
    lsu_request = 1'b1; lsu_we_re = 1'b0; lsu_mask = 4'hF; lsu_addr = 32'h80; lsu_wdata = 32'h1234;
    tick();
    check_port("pre_abort", 1'b1, 1'b0, 4'hF, 32'h80, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0; lsu_request = 1'b0;
    check_port("abort", 1'b0, 1'b0, 4'h0, '0, '0);
    tick();
    check("abort_stays_idle", DW'(mem_request), '0);

    // Load whose request drops mid-transaction still completes; wdata zero for loads.
    lsu_request = 1'b1; lsu_we_re = 1'b0; lsu_mask = 4'hF; lsu_addr = 32'h200; lsu_wdata = 32'hFFFF;
    tick();
    check_port("load", 1'b1, 1'b0, 4'hF, 32'h200, '0);
    tick();
    lsu_request = 1'b0;
    tick();
    check_port("load_after_drop", 1'b1, 1'b0, 4'hF, 32'h200, '0);
    push(1'b1, 32'h12345678, 1'b0);
    mem_rdata = 32'h12345678; mem_data_valid = 1'b1;
    tick();
    mem_data_valid = 1'b0;
    check("load_done_mem_request", DW'(mem_request), '0);
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // Silent memory: abort in the fourth serve cycle with rdata 0.
    lsu_request = 1'b1; lsu_we_re = 1'b0; lsu_mask = 4'hF; lsu_addr = 32'h300;
    mem_rdata = 32'h77777777;
    tick();
    tick();
    tick();
    check("to_not_yet", DW'(timeout_err), '0);
    push(1'b1, '0, 1'b1);
    tick();
    check("to_fire_direct", DW'(timeout_err), 32'h1);
    tick();
    lsu_request = 1'b0;
    check("to_back_idle", DW'(mem_request), '0);
    tick();

    // Completion coinciding with the limit is a normal completion.
    lsu_request = 1'b1; lsu_addr = 32'h304;
    tick();
    tick();
    tick();
    tick();
    push(1'b1, 32'h0BADF00D, 1'b0);
    mem_rdata = 32'h0BADF00D; mem_data_valid = 1'b1;
    tick();
    mem_data_valid = 1'b0; lsu_request = 1'b0;
    check("to_tie_idle", DW'(mem_request), '0);
    tick();
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("scoreboard_drained", DW'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
